// File: rtl/huff_pkg.sv
// Shared widths, FSM encoding and error codes for the Huffman stream sequencer.
package huff_pkg;

   localparam int WORD_W  = 32;
   localparam int BUF_W   = 2 * WORD_W;
   localparam int WIN_W   = 6;
   localparam int SYM_W   = 4;
   localparam int LEN_W   = 4;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 255;

   localparam int AVAIL_W = $clog2(BUF_W + 1);
   localparam int WAIT_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   typedef logic [1:0] err_t;

   localparam err_t ERR_NONE    = 2'b00;
   localparam err_t ERR_LEN     = 2'b01;
   localparam err_t ERR_TIMEOUT = 2'b10;

   // A code length is usable only if it fits inside the presented window.
   function automatic logic len_legal(input logic [LEN_W-1:0] len);
      return (len != '0) && (len <= LEN_W'(WIN_W));
   endfunction

endpackage

// File: rtl/huff_stream_sequencer_if.sv
// Word source, decoder, symbol sink and control/status signals of the sequencer.
interface huff_stream_sequencer_if;
   import huff_pkg::*;

   logic              start;
   logic [CNT_W-1:0]  num_symbols;

   logic              word_valid;
   logic [WORD_W-1:0] word_data;
   logic              word_ready;

   logic [WIN_W-1:0]  win_data;
   logic              win_valid;
   logic              dec_done;
   logic [SYM_W-1:0]  dec_symbol;
   logic [LEN_W-1:0]  dec_len;

   logic              out_valid;
   logic [SYM_W-1:0]  out_symbol;
   logic              out_ready;

   logic              busy;
   logic              done;
   logic [1:0]        err;

   modport slave (
      input  start, num_symbols, word_valid, word_data,
             dec_done, dec_symbol, dec_len, out_ready,
      output word_ready, win_data, win_valid, out_valid, out_symbol,
             busy, done, err
   );

   modport master (
      output start, num_symbols, word_valid, word_data,
             dec_done, dec_symbol, dec_len, out_ready,
      input  word_ready, win_data, win_valid, out_valid, out_symbol,
             busy, done, err
   );

endinterface

// File: rtl/huff_bit_buffer.sv
// 64-bit MSB-aligned bit buffer: pop shifts out len bits, push appends a word after the
// remaining bits; when both happen in one cycle the shift is applied before the append.
module huff_bit_buffer
   import huff_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               push_i,
   input  logic [WORD_W-1:0]  word_i,
   input  logic               pop_i,
   input  logic [LEN_W-1:0]   len_i,
   output logic [WIN_W-1:0]   window_o,
   output logic [AVAIL_W-1:0] bits_avail_o,
   output logic               can_push_o
);

   logic [BUF_W-1:0]   bits_q;
   logic [BUF_W-1:0]   bits_d;
   logic [BUF_W-1:0]   shifted;
   logic [AVAIL_W-1:0] avail_q;
   logic [AVAIL_W-1:0] avail_d;
   logic [AVAIL_W-1:0] avail_s;

   // Bits below the valid region are always zero, so an OR is enough to append.
   always_comb begin
      shifted = bits_q;
      avail_s = avail_q;
      if (pop_i) begin
         shifted = bits_q << len_i;
         avail_s = avail_q - AVAIL_W'(len_i);
      end
      bits_d  = shifted;
      avail_d = avail_s;
      if (push_i) begin
         bits_d  = shifted | ({word_i, {WORD_W{1'b0}}} >> avail_s);
         avail_d = avail_s + AVAIL_W'(WORD_W);
      end
      if (clr_i) begin
         bits_d  = '0;
         avail_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bits_q  <= '0;
         avail_q <= '0;
      end else begin
         bits_q  <= bits_d;
         avail_q <= avail_d;
      end
   end

   assign window_o     = bits_q[BUF_W-1 -: WIN_W];
   assign bits_avail_o = avail_q;
   assign can_push_o   = (avail_q <= AVAIL_W'(BUF_W - WORD_W));

endmodule

// File: rtl/huff_stream_sequencer.sv
// Drives the Huffman decoder over a packed bitstream: one window per symbol, symbol out on
// valid/ready; out_ready low stalls in EMIT, word_ready drops once more than 32 bits are buffered.
module huff_stream_sequencer
   import huff_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   huff_stream_sequencer_if.slave bus
);

   state_t             state_q;
   logic [CNT_W-1:0]   total_q;
   logic [CNT_W-1:0]   count_q;
   logic [WAIT_W-1:0]  wait_cnt_q;
   logic               win_valid_q;
   logic               out_valid_q;
   logic [SYM_W-1:0]   out_symbol_q;
   logic               busy_q;
   logic               done_q;
   err_t               err_q;

   logic               start_ok;
   logic               push;
   logic               pop;
   logic               can_push;
   logic [WIN_W-1:0]   window;
   logic [AVAIL_W-1:0] bits_avail;

   assign start_ok = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign push     = bus.word_valid && bus.word_ready;
   // The buffer only moves on an accepted decode; the window stays frozen otherwise.
   assign pop      = (state_q == S_WAIT) && bus.dec_done && len_legal(bus.dec_len);

   huff_bit_buffer u_buf (
      .clk          (clk),
      .rst          (rst),
      .clr_i        (start_ok),
      .push_i       (push),
      .word_i       (bus.word_data),
      .pop_i        (pop),
      .len_i        (bus.dec_len),
      .window_o     (window),
      .bits_avail_o (bits_avail),
      .can_push_o   (can_push)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         total_q      <= '0;
         count_q      <= '0;
         wait_cnt_q   <= '0;
         win_valid_q  <= 1'b0;
         out_valid_q  <= 1'b0;
         out_symbol_q <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= ERR_NONE;
      end else begin
         win_valid_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  total_q     <= bus.num_symbols;
                  count_q     <= '0;
                  wait_cnt_q  <= '0;
                  err_q       <= ERR_NONE;
                  out_valid_q <= 1'b0;
                  if (bus.num_symbols == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_FILL;
                     done_q  <= 1'b0;
                     busy_q  <= 1'b1;
                  end
               end
            end

            S_FILL: begin
               if (bits_avail >= AVAIL_W'(WIN_W)) begin
                  state_q     <= S_ISSUE;
                  win_valid_q <= 1'b1;
               end
            end

            S_ISSUE: begin
               state_q    <= S_WAIT;
               wait_cnt_q <= '0;
            end

            S_WAIT: begin
               if (bus.dec_done) begin
                  if (len_legal(bus.dec_len)) begin
                     out_symbol_q <= bus.dec_symbol;
                     out_valid_q  <= 1'b1;
                     state_q      <= S_EMIT;
                  end else begin
                     err_q   <= ERR_LEN;
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end
               end else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                  err_q   <= ERR_TIMEOUT;
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
            end

            S_EMIT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  count_q     <= count_q + CNT_W'(1);
                  if (count_q + CNT_W'(1) == total_q) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_FILL;
                  end
               end
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.word_ready = busy_q && can_push;
   assign bus.win_data   = window;
   assign bus.win_valid  = win_valid_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_symbol = out_symbol_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;

endmodule

// File: tb/tb_huff_stream_sequencer.sv
// Bench for huff_stream_sequencer: randomized streams checked against a bit-queue model
// of the compressed stream, plus directed error, timeout, zero-count and reset scenarios.
module tb_huff_stream_sequencer;
   import huff_pkg::*;

   logic clk = 1'b0;
   logic rst;

   huff_stream_sequencer_if bus ();

   huff_stream_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   int          sym_q[$];
   int          len_q[$];
   logic [31:0] words_q[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start       = 1'b0;
      bus.num_symbols = '0;
      bus.word_valid  = 1'b0;
      bus.word_data   = '0;
      bus.dec_done    = 1'b0;
      bus.dec_symbol  = '0;
      bus.dec_len     = '0;
      bus.out_ready   = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Random codes of length minl..maxl, then zero padding of at least one window.
   task automatic build_random(input int n, input int minl, input int maxl);
      bit b[$];
      logic [31:0] w;
      sym_q.delete();
      len_q.delete();
      words_q.delete();
      for (int i = 0; i < n; i++) begin
         int l;
         l = $urandom_range(maxl, minl);
         sym_q.push_back($urandom_range(15, 0));
         len_q.push_back(l);
         for (int k = 0; k < l; k++) b.push_back(1'($urandom_range(1, 0)));
      end
      for (int k = 0; k < WIN_W; k++) b.push_back(1'b0);
      while ((b.size() % 32) != 0) b.push_back(1'b0);
      for (int i = 0; i < b.size() / 32; i++) begin
         for (int k = 0; k < 32; k++) w[31-k] = b[i*32+k];
         words_q.push_back(w);
      end
   endtask

   // Runs one stream from start to done. The model is the bit queue of all words plus
   // counts of accepted words and consumed bits.
   task automatic run_stream(input string name, input int hold, input int rdy_pct, input int spur);
      bit stream[$];
      int nsym, acc, cons, so, se, wi, dly, didx, held, cyc, avail_m, fill_at;
      bit running, fin, last_ov, hs, w_acc, ov_chk, exp_win_next;
      logic [SYM_W-1:0] last_sym;
      logic [WIN_W-1:0] exp_win;

      nsym = sym_q.size();
      foreach (words_q[w]) for (int k = 31; k >= 0; k--) stream.push_back(words_q[w][k]);
      acc = 0; cons = 0; so = 0; se = 0; wi = 0; dly = -1; didx = 0; held = 0; cyc = 0;
      fill_at = 0; running = 1; fin = 0; last_ov = 0; w_acc = 0; ov_chk = 0;
      exp_win_next = 0; last_sym = '0;

      bus.start       = 1'b1;
      bus.num_symbols = CNT_W'(nsym);
      tick();
      bus.start = 1'b0;

      while (!fin && cyc < 20000) begin
         avail_m = acc * 32 - cons;
         if (w_acc) begin
            bus.word_valid = 1'b0;
            w_acc = 0;
         end
         if (bus.done) begin
            fin = 1;
         end else begin
            if (ov_chk) begin
               n_vec++;
               if (bus.out_valid !== 1'b1) begin
                  n_err++;
                  $display("FAIL %s dec_to_out_latency: out_valid=%b, expected 1", name, bus.out_valid);
               end
               ov_chk = 0;
            end
            if (fill_at == 2) begin
               if (exp_win_next) begin
                  n_vec++;
                  if (bus.win_valid !== 1'b1) begin
                     n_err++;
                     $display("FAIL %s handshake_to_win_latency: win_valid=%b, expected 1", name, bus.win_valid);
                  end
               end
               fill_at = 0;
            end
            if (fill_at == 1) begin
               exp_win_next = (avail_m >= WIN_W);
               fill_at = 2;
            end
            if (bus.win_valid) begin
               for (int k = 0; k < WIN_W; k++)
                  exp_win[WIN_W-1-k] = (cons + k < stream.size()) ? stream[cons+k] : 1'b0;
               n_vec++;
               if (bus.win_data !== exp_win) begin
                  n_err++;
                  $display("FAIL %s win_data sym %0d: got %b, expected %b", name, so, bus.win_data, exp_win);
               end
               n_vec++;
               if (dly >= 0 || so >= nsym || bus.out_valid) begin
                  n_err++;
                  $display("FAIL %s unexpected_win_valid: issued=%0d of %0d, out_valid=%b", name, so, nsym, bus.out_valid);
               end
               if (so < nsym) begin
                  dly  = $urandom_range(4, 1);
                  didx = so;
                  so++;
               end
            end
            n_vec++;
            if (bus.word_ready !== (running && avail_m <= 32)) begin
               n_err++;
               $display("FAIL %s word_ready: got %b, expected %b (model bits %0d)", name, bus.word_ready, (running && avail_m <= 32), avail_m);
            end
            if (last_ov && bus.out_valid) begin
               n_vec++;
               if (bus.out_symbol !== last_sym) begin
                  n_err++;
                  $display("FAIL %s out_symbol_stable: got %h, expected %h", name, bus.out_symbol, last_sym);
               end
            end

            bus.dec_done = 1'b0;
            if (dly == 0) begin
               bus.dec_done   = 1'b1;
               bus.dec_symbol = SYM_W'(sym_q[didx]);
               bus.dec_len    = LEN_W'(len_q[didx]);
               cons += len_q[didx];
               dly = -1;
               ov_chk = 1;
            end else if (dly > 0) begin
               dly--;
            end

            if (!bus.word_valid && wi < words_q.size() && $urandom_range(3, 0) != 0) begin
               bus.word_valid = 1'b1;
               bus.word_data  = words_q[wi];
            end
            if (bus.word_valid && bus.word_ready) begin
               acc++;
               wi++;
               w_acc = 1;
            end

            if (bus.out_valid) held++;
            else held = 0;
            bus.out_ready = (held > hold) && ($urandom_range(99, 0) < rdy_pct);
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
               n_vec++;
               if (se >= nsym || bus.out_symbol !== SYM_W'(sym_q[se])) begin
                  n_err++;
                  $display("FAIL %s out_symbol #%0d: got %h, expected %h", name, se, bus.out_symbol, (se < nsym) ? sym_q[se] : -1);
               end
               se++;
               held = 0;
               if (se == nsym) running = 0;
               else fill_at = 1;
            end
            last_ov  = bus.out_valid && !hs;
            last_sym = bus.out_symbol;

            bus.start = (cyc == spur);
            if (cyc == spur) bus.num_symbols = CNT_W'(1);

            tick();
            cyc++;
         end
      end
      idle_inputs();

      n_vec++;
      if (!fin) begin
         n_err++;
         $display("FAIL %s done_timeout: done=%b after %0d cycles, expected 1", name, bus.done, cyc);
      end else begin
         n_vec++;
         if (bus.err !== ERR_NONE || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s final_status: err=%b busy=%b, expected err=00 busy=0", name, bus.err, bus.busy);
         end
         n_vec++;
         if (se != nsym || so != nsym) begin
            n_err++;
            $display("FAIL %s symbol_count: issued=%0d emitted=%0d, expected %0d", name, so, se, nsym);
         end
         n_vec++;
         if (dut.bits_avail !== 7'(acc * 32 - cons)) begin
            n_err++;
            $display("FAIL %s final_bits_avail: got %0d, expected %0d", name, dut.bits_avail, acc * 32 - cons);
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({bus.word_ready, bus.win_valid, bus.out_valid, bus.busy, bus.done, bus.err} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b, expected 0000000", {bus.word_ready, bus.win_valid, bus.out_valid, bus.busy, bus.done, bus.err});
      end
      n_vec++;
      if (bus.win_data !== '0 || bus.out_symbol !== '0 || dut.bits_avail !== '0) begin
         n_err++;
         $display("FAIL reset_data: win=%b sym=%h bits=%0d, expected all 0", bus.win_data, bus.out_symbol, dut.bits_avail);
      end
   endtask

   task automatic test_basic();
      do_reset();
      sym_q = '{0, 9, 0};
      len_q = '{1, 4, 1};
      words_q = '{32'hB000_0000};
      run_stream("basic", 0, 100, -1);
   endtask

   task automatic test_six_bit_codes();
      do_reset();
      sym_q.delete();
      len_q.delete();
      for (int i = 0; i < 12; i++) begin
         sym_q.push_back($urandom_range(15, 0));
         len_q.push_back(6);
      end
      words_q = '{32'h6186_1861, 32'h8618_6186, 32'h1861_8618};
      run_stream("six_bit", 0, 100, -1);
   endtask

   task automatic test_random_streams();
      for (int r = 0; r < 3; r++) begin
         build_random(20, 1, 6);
         run_stream("random", 0, 60, -1);
      end
   endtask

   task automatic test_backpressure();
      build_random(4, 1, 6);
      run_stream("backpressure", 5, 100, -1);
   endtask

   task automatic test_bad_len();
      int cyc;
      do_reset();
      for (int pass = 0; pass < 2; pass++) begin
         bus.start       = 1'b1;
         bus.num_symbols = 16'd2;
         bus.word_valid  = 1'b1;
         bus.word_data   = $urandom;
         tick();
         bus.start = 1'b0;
         n_vec++;
         if (bus.err !== ERR_NONE || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_err++;
            $display("FAIL bad_len_start pass %0d: err=%b busy=%b done=%b, expected 00 1 0", pass, bus.err, bus.busy, bus.done);
         end
         tick();
         bus.word_valid = 1'b0;
         cyc = 0;
         while (!bus.win_valid && cyc < 20) begin
            tick();
            cyc++;
         end
         tick();
         bus.dec_done   = 1'b1;
         bus.dec_symbol = 4'd3;
         bus.dec_len    = (pass == 0) ? 4'd7 : 4'd0;
         tick();
         bus.dec_done = 1'b0;
         n_vec++;
         if (bus.done !== 1'b1 || bus.err !== ERR_LEN || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bad_len pass %0d: done=%b err=%b out_valid=%b, expected 1 01 0", pass, bus.done, bus.err, bus.out_valid);
         end
         n_vec++;
         if (dut.bits_avail !== 7'd32) begin
            n_err++;
            $display("FAIL bad_len_not_consumed pass %0d: bits=%0d, expected 32", pass, dut.bits_avail);
         end
         tick();
         tick();
      end
   endtask

   task automatic test_timeout();
      int cyc;
      bit ov_seen;
      do_reset();
      bus.start       = 1'b1;
      bus.num_symbols = 16'd1;
      bus.word_valid  = 1'b1;
      bus.word_data   = $urandom;
      tick();
      bus.start = 1'b0;
      tick();
      bus.word_valid = 1'b0;
      cyc = 0;
      while (!bus.win_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      cyc = 0;
      ov_seen = 0;
      while (!bus.done && cyc < 400) begin
         tick();
         cyc++;
         if (bus.out_valid) ov_seen = 1;
      end
      n_vec++;
      if (bus.done !== 1'b1 || bus.err !== ERR_TIMEOUT || ov_seen) begin
         n_err++;
         $display("FAIL timeout_status: done=%b err=%b out_valid_seen=%b, expected 1 10 0", bus.done, bus.err, ov_seen);
      end
      n_vec++;
      if (cyc < 250 || cyc > 260) begin
         n_err++;
         $display("FAIL timeout_cycles: got %0d, expected about 256", cyc);
      end
   endtask

   task automatic test_zero_and_spurious();
      do_reset();
      bus.word_valid  = 1'b1;
      bus.word_data   = $urandom;
      bus.start       = 1'b1;
      bus.num_symbols = '0;
      tick();
      bus.start = 1'b0;
      n_vec++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.word_ready !== 1'b0 || bus.err !== ERR_NONE) begin
         n_err++;
         $display("FAIL zero_count: done=%b busy=%b word_ready=%b err=%b, expected 1 0 0 00", bus.done, bus.busy, bus.word_ready, bus.err);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (bus.win_valid !== 1'b0 || bus.word_ready !== 1'b0) begin
            n_err++;
            $display("FAIL zero_count_quiet: win_valid=%b word_ready=%b, expected 0 0", bus.win_valid, bus.word_ready);
         end
      end
      bus.word_valid = 1'b0;
      build_random(5, 1, 6);
      run_stream("spurious_start", 0, 80, 3);
   endtask

   task automatic test_reset_mid();
      int cyc;
      do_reset();
      build_random(4, 1, 6);
      bus.start       = 1'b1;
      bus.num_symbols = 16'd4;
      bus.word_valid  = 1'b1;
      bus.word_data   = words_q[0];
      tick();
      bus.start = 1'b0;
      cyc = 0;
      while (!bus.win_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      tick();
      rst            = 1'b1;
      bus.word_valid = 1'b1;
      tick();
      rst = 1'b0;
      n_vec++;
      if ({bus.word_ready, bus.win_valid, bus.out_valid, bus.busy, bus.done, bus.err} !== 7'b0 ||
          bus.win_data !== '0 || bus.out_symbol !== '0 || dut.bits_avail !== '0) begin
         n_err++;
         $display("FAIL reset_mid: flags=%b win=%b sym=%h bits=%0d, expected all 0",
                  {bus.word_ready, bus.win_valid, bus.out_valid, bus.busy, bus.done, bus.err},
                  bus.win_data, bus.out_symbol, dut.bits_avail);
      end
      idle_inputs();
      tick();
      build_random(6, 1, 6);
      run_stream("after_reset", 0, 90, -1);
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_six_bit_codes();
      test_random_streams();
      test_backpressure();
      test_bad_len();
      test_timeout();
      test_zero_and_spurious();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/huff_stream_sequencer.md
Name: huff_stream_sequencer

Overview:
Sequences the Huffman symbol decoder core over a packed compressed bitstream. It accepts 32-bit words from an upstream word source and keeps them in a 64-bit MSB-aligned bit buffer. For each symbol it presents a 6-bit window to the decoder and consumes the reported code length. Decoded symbols go downstream over valid/ready, and the block stops after a programmed symbol count.

Parameters:
WORD_W, 32, width of upstream bitstream words
BUF_W, 64, bit buffer width (2*WORD_W)
WIN_W, 6, decoder window width (maximum code length)
SYM_W, 4, decoded symbol width
LEN_W, 4, code length field width
CNT_W, 16, symbol counter width
TIMEOUT, 255, maximum WAIT cycles before a decoder timeout error

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse that starts a stream; ignored unless the state is IDLE or DONE
num_symbols  in  CNT_W  number of symbols to decode; sampled on start
word_valid  in  1  upstream word available
word_data  in  WORD_W  upstream word, MSB is the first bit
word_ready  out  1  word accepted when word_valid&&word_ready
win_data  out  WIN_W  top WIN_W bits of the buffer (buf[BUF_W-1 -: WIN_W])
win_valid  out  1  one-cycle pulse: decoder should start decoding win_data
dec_done  in  1  decoder result pulse
dec_symbol  in  SYM_W  decoded symbol, valid with dec_done
dec_len  in  LEN_W  code length in bits, valid with dec_done
out_valid  out  1  decoded symbol available
out_symbol  out  SYM_W  decoded symbol
out_ready  in  1  downstream accepts the symbol
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE
err  out  2  00 none, 01 bad length, 10 decoder timeout; valid in DONE, cleared on start

Behaviour:
- Reset: state=IDLE; buffer=0; bits_avail=0; count=0; wait_cnt=0. Every output is 0, including word_ready, win_valid, out_valid, busy, done and err.
- Reset mid-stream discards the buffer and any pending symbol. Nothing is emitted after the reset edge.
- bits_avail counts 0..BUF_W. Valid bits are left-aligned at buf[BUF_W-1].
- Refill:
  - word_ready = busy && bits_avail <= BUF_W-WORD_W.
  - On accept, the word is placed at bit offset (BUF_W-bits_avail_after_consume-1) downward.
  - bits_avail increases by WORD_W.
- Consume: on a legal dec_done, buf <<= dec_len (zero fill) and bits_avail -= dec_len.
- Simultaneous accept and consume in one cycle:
  - The shift is applied first, then the append at the post-shift offset.
  - bits_avail_next = bits_avail - dec_len + WORD_W.
  - No bit may be lost or duplicated.
- Producer rule: the stream is zero-padded so at least WIN_W bits exist beyond the last code.
- FSM:
  - IDLE: wait for start. Latch total=num_symbols, clear buffer, count and err. If num_symbols==0, go to DONE; otherwise go to FILL.
  - FILL: go to ISSUE when bits_avail>=WIN_W.
  - ISSUE: win_valid=1 for exactly one cycle with a stable win_data. Go to WAIT and clear wait_cnt.
  - WAIT: the buffer must not shift; refill is still permitted. wait_cnt increments each cycle.
    - On dec_done with 1<=dec_len<=WIN_W: consume, out_symbol<=dec_symbol, go to EMIT.
    - On dec_done with dec_len==0 or dec_len>WIN_W: err=01, go to DONE, buffer not consumed.
    - When wait_cnt reaches TIMEOUT with no dec_done: err=10, go to DONE.
    - dec_done outside WAIT is ignored.
  - EMIT: out_valid=1; out_symbol stays stable until out_ready. On handshake count++. If count+1==total go to DONE, else go to FILL.
  - DONE: done=1 and busy=0, held until start. start re-arms from DONE exactly as from IDLE.
- Latency with the buffer already holding WIN_W bits:
  - FILL to win_valid: 1 cycle.
  - dec_done to out_valid: 1 cycle.
  - out handshake to the next win_valid: 2 cycles (FILL, ISSUE).
- start during busy has no effect. word_valid while word_ready=0 is held by the producer.

Decomposition:
- Shared package huff_pkg:
  - Width constants WORD_W, WIN_W, SYM_W, LEN_W.
  - FSM state encoding (IDLE, FILL, ISSUE, WAIT, EMIT, DONE).
  - err code constants ERR_NONE, ERR_LEN, ERR_TIMEOUT.
- One sub-module, huff_bit_buffer, which holds the buffer and bits_avail.
  - Inputs: clr, push+word, pop+len.
  - Outputs: window, bits_avail, can_push.
- The sequencer instantiates huff_bit_buffer and contains only the FSM and counters.

Test Plan:
- num_symbols=3; word 0xB0000000; decoder model returns (sym 0, len 1), (sym 9, len 4), (sym 0, len 1); out_ready=1 -> win_data 6'b101100, then 6'b011000, then 6'b000000; out_symbol 0,9,0; done=1, err=00, bits_avail ends at 26.
- num_symbols=12, six-bit codes only; words 0x61861861, 0x86186186, ... -> word_ready drops when bits_avail>32; a refill in the same cycle as a consume preserves bit order; out_symbol sequence matches the model.
- out_ready held low 5 cycles in EMIT -> out_valid and out_symbol stable for all 5 cycles; no new win_valid; count unchanged until the handshake.
- Decoder returns dec_len=7 -> err=01, done=1, no out_valid. Decoder silent for 255 cycles in a separate run -> err=10, done=1.
- start with num_symbols=0 -> DONE the next cycle, with no word_ready and no win_valid. A second start during busy is ignored.
- rst asserted in WAIT with word_valid high -> next cycle every output is 0 and state is IDLE. A new start decodes from a fresh buffer.
